// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter: m0 (instruction fetch) and m1 (load/store) share one slave.
// Whole transactions are granted round-robin, so the slave only ever sees one master at a time.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8,
    parameter int RESP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (IFU)
    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic              m0_arvalid_i,
    output logic              m0_arready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [RESP_W-1:0] m0_rresp_o,
    output logic              m0_rvalid_o,
    input  logic              m0_rready_i,
    input  logic [ADDR_W-1:0] m0_awaddr_i,
    input  logic              m0_awvalid_i,
    output logic              m0_awready_o,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [STRB_W-1:0] m0_wstrb_i,
    input  logic              m0_wvalid_i,
    output logic              m0_wready_o,
    output logic [RESP_W-1:0] m0_bresp_o,
    output logic              m0_bvalid_o,
    input  logic              m0_bready_i,
    // master 1 (LSU)
    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic              m1_arvalid_i,
    output logic              m1_arready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [RESP_W-1:0] m1_rresp_o,
    output logic              m1_rvalid_o,
    input  logic              m1_rready_i,
    input  logic [ADDR_W-1:0] m1_awaddr_i,
    input  logic              m1_awvalid_i,
    output logic              m1_awready_o,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [STRB_W-1:0] m1_wstrb_i,
    input  logic              m1_wvalid_i,
    output logic              m1_wready_o,
    output logic [RESP_W-1:0] m1_bresp_o,
    output logic              m1_bvalid_o,
    input  logic              m1_bready_i,
    // shared slave
    output logic [ADDR_W-1:0] s_araddr_o,
    output logic              s_arvalid_o,
    input  logic              s_arready_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic [RESP_W-1:0] s_rresp_i,
    input  logic              s_rvalid_i,
    output logic              s_rready_o,
    output logic [ADDR_W-1:0] s_awaddr_o,
    output logic              s_awvalid_o,
    input  logic              s_awready_i,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic [STRB_W-1:0] s_wstrb_o,
    output logic              s_wvalid_o,
    input  logic              s_wready_i,
    input  logic [RESP_W-1:0] s_bresp_i,
    input  logic              s_bvalid_i,
    output logic              s_bready_o
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last_grant, last_grant_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;
    logic   grant;

    logic [1:0] rd_req, wr_req, req;
    assign rd_req = {m1_arvalid_i, m0_arvalid_i};
    assign wr_req = {m1_awvalid_i | m1_wvalid_i, m0_awvalid_i | m0_wvalid_i};
    assign req    = rd_req | wr_req;

    // Owner's request side, selected purely by the registered owner.
    logic [ADDR_W-1:0] sel_araddr, sel_awaddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;

    assign sel_araddr  = owner ? m1_araddr_i  : m0_araddr_i;
    assign sel_arvalid = owner ? m1_arvalid_i : m0_arvalid_i;
    assign sel_rready  = owner ? m1_rready_i  : m0_rready_i;
    assign sel_awaddr  = owner ? m1_awaddr_i  : m0_awaddr_i;
    assign sel_awvalid = owner ? m1_awvalid_i : m0_awvalid_i;
    assign sel_wdata   = owner ? m1_wdata_i   : m0_wdata_i;
    assign sel_wstrb   = owner ? m1_wstrb_i   : m0_wstrb_i;
    assign sel_wvalid  = owner ? m1_wvalid_i  : m0_wvalid_i;
    assign sel_bready  = owner ? m1_bready_i  : m0_bready_i;

    logic in_rd_addr, in_rd_data, in_wr, in_wr_resp;
    assign in_rd_addr = (state == RD_ADDR);
    assign in_rd_data = (state == RD_DATA);
    assign in_wr      = (state == WR);
    assign in_wr_resp = (state == WR_RESP);

    // Slave side: every valid/ready is qualified by state, so nothing leaks through in IDLE.
    assign s_arvalid_o = in_rd_addr & sel_arvalid;
    assign s_araddr_o  = in_rd_addr ? sel_araddr : '0;
    assign s_rready_o  = in_rd_data & sel_rready;
    assign s_awvalid_o = in_wr & ~aw_done & sel_awvalid;
    assign s_awaddr_o  = in_wr ? sel_awaddr : '0;
    assign s_wvalid_o  = in_wr & ~w_done & sel_wvalid;
    assign s_wdata_o   = in_wr ? sel_wdata : '0;
    assign s_wstrb_o   = in_wr ? sel_wstrb : '0;
    assign s_bready_o  = in_wr_resp & sel_bready;

    logic              own_arready, own_rvalid, own_awready, own_wready, own_bvalid;
    logic [DATA_W-1:0] own_rdata;
    logic [RESP_W-1:0] own_rresp, own_bresp;

    assign own_arready = in_rd_addr & s_arready_i;
    assign own_rvalid  = in_rd_data & s_rvalid_i;
    assign own_rdata   = in_rd_data ? s_rdata_i : '0;
    assign own_rresp   = in_rd_data ? s_rresp_i : '0;
    assign own_awready = in_wr & ~aw_done & s_awready_i;
    assign own_wready  = in_wr & ~w_done & s_wready_i;
    assign own_bvalid  = in_wr_resp & s_bvalid_i;
    assign own_bresp   = in_wr_resp ? s_bresp_i : '0;

    assign m0_arready_o = ~owner & own_arready;
    assign m0_rvalid_o  = ~owner & own_rvalid;
    assign m0_rdata_o   = owner ? '0 : own_rdata;
    assign m0_rresp_o   = owner ? '0 : own_rresp;
    assign m0_awready_o = ~owner & own_awready;
    assign m0_wready_o  = ~owner & own_wready;
    assign m0_bvalid_o  = ~owner & own_bvalid;
    assign m0_bresp_o   = owner ? '0 : own_bresp;

    assign m1_arready_o = owner & own_arready;
    assign m1_rvalid_o  = owner & own_rvalid;
    assign m1_rdata_o   = owner ? own_rdata : '0;
    assign m1_rresp_o   = owner ? own_rresp : '0;
    assign m1_awready_o = owner & own_awready;
    assign m1_wready_o  = owner & own_wready;
    assign m1_bvalid_o  = owner & own_bvalid;
    assign m1_bresp_o   = owner ? own_bresp : '0;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = s_arvalid_o & s_arready_i;
    assign r_hs  = s_rvalid_i & s_rready_o;
    assign aw_hs = s_awvalid_o & s_awready_i;
    assign w_hs  = s_wvalid_o & s_wready_i;
    assign b_hs  = s_bvalid_i & s_bready_o;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        grant          = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant          = (&req) ? ~last_grant : req[1];
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    // A master presenting both a read and a write is served the read first.
                    state_nxt      = rd_req[grant] ? RD_ADDR : WR;
                end
            end
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs)  state_nxt = IDLE;
            WR: begin
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt   = IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed cycle checks plus randomized two-master traffic
// scored against a transaction-level model of the round-robin sharing rules.
module tb_axi_lite_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int RESP_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic [1:0] m_wvalid, m_wready, m_bvalid, m_bready;
    logic [ADDR_W-1:0] m_araddr [2];
    logic [ADDR_W-1:0] m_awaddr [2];
    logic [DATA_W-1:0] m_rdata  [2];
    logic [DATA_W-1:0] m_wdata  [2];
    logic [RESP_W-1:0] m_rresp  [2];
    logic [RESP_W-1:0] m_bresp  [2];
    logic [STRB_W-1:0] m_wstrb  [2];

    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [DATA_W-1:0] s_rdata, s_wdata;
    logic [RESP_W-1:0] s_rresp, s_bresp;
    logic [STRB_W-1:0] s_wstrb;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_bvalid, s_bready;

    axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .RESP_W(RESP_W)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr_i(m_araddr[0]), .m0_arvalid_i(m_arvalid[0]), .m0_arready_o(m_arready[0]),
        .m0_rdata_o(m_rdata[0]), .m0_rresp_o(m_rresp[0]), .m0_rvalid_o(m_rvalid[0]),
        .m0_rready_i(m_rready[0]), .m0_awaddr_i(m_awaddr[0]), .m0_awvalid_i(m_awvalid[0]),
        .m0_awready_o(m_awready[0]), .m0_wdata_i(m_wdata[0]), .m0_wstrb_i(m_wstrb[0]),
        .m0_wvalid_i(m_wvalid[0]), .m0_wready_o(m_wready[0]), .m0_bresp_o(m_bresp[0]),
        .m0_bvalid_o(m_bvalid[0]), .m0_bready_i(m_bready[0]),
        .m1_araddr_i(m_araddr[1]), .m1_arvalid_i(m_arvalid[1]), .m1_arready_o(m_arready[1]),
        .m1_rdata_o(m_rdata[1]), .m1_rresp_o(m_rresp[1]), .m1_rvalid_o(m_rvalid[1]),
        .m1_rready_i(m_rready[1]), .m1_awaddr_i(m_awaddr[1]), .m1_awvalid_i(m_awvalid[1]),
        .m1_awready_o(m_awready[1]), .m1_wdata_i(m_wdata[1]), .m1_wstrb_i(m_wstrb[1]),
        .m1_wvalid_i(m_wvalid[1]), .m1_wready_o(m_wready[1]), .m1_bresp_o(m_bresp[1]),
        .m1_bvalid_o(m_bvalid[1]), .m1_bready_i(m_bready[1]),
        .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
        .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave response data is a fixed function of the address, so routing errors show up.
    function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction
    function automatic logic [RESP_W-1:0] rresp_fn(input logic [ADDR_W-1:0] a);
        return a ^ 32'h0000_F00D;
    endfunction
    function automatic logic [RESP_W-1:0] bresp_fn(input logic [ADDR_W-1:0] a);
        return {a[15:0], a[31:16]};
    endfunction

    function automatic logic [14:0] hs_bits();
        return {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    function automatic logic [4:0] m_bits(input int i);
        return {m_arready[i], m_rvalid[i], m_awready[i], m_wready[i], m_bvalid[i]};
    endfunction

    task automatic clear_inputs();
        m_arvalid = '0; m_rready = '0; m_awvalid = '0; m_wvalid = '0; m_bready = '0;
        for (int i = 0; i < 2; i++) begin
            m_araddr[i] = '0; m_awaddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    endtask

    // Payloads and slave valids are driven non-zero during reset to prove all outputs are gated.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_araddr[i] = '1; m_awaddr[i] = '1; m_wdata[i] = '1; m_wstrb[i] = '1;
        end
        m_rready = '1; m_bready = '1;
        s_rvalid = 1'b1; s_bvalid = 1'b1; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rdata = '1; s_rresp = '1; s_bresp = '1;
        @(negedge clk); #1;
        check("rst_handshakes", 64'(hs_bits()), 64'd0);
        check("rst_rdata", m_rdata[0] | m_rdata[1], 64'd0);
        check("rst_resp", 64'(m_rresp[0] | m_rresp[1] | m_bresp[0] | m_bresp[1]), 64'd0);
        check("rst_s_payload", s_wdata | 64'(s_araddr | s_awaddr | 32'(s_wstrb)), 64'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic read_m0(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        m_arvalid[0] = 1'b1; m_araddr[0] = addr;
        #1 check("rd_idle_quiet", 64'(hs_bits()), 64'd0);
        @(negedge clk);
        s_arready = 1'b1;
        #1 check("rd_s_arvalid", 64'(s_arvalid), 64'd1);
        check("rd_s_araddr", 64'(s_araddr), 64'(addr));
        check("rd_m0_arready", 64'(m_arready[0]), 64'd1);
        check("rd_m1_quiet_a", 64'(m_bits(1)), 64'd0);
        @(negedge clk);
        m_arvalid[0] = 1'b0; s_arready = 1'b0; m_rready[0] = 1'b1;
        s_rvalid = 1'b1; s_rdata = data; s_rresp = 32'h7;
        #1 check("rd_m0_rvalid", 64'(m_rvalid[0]), 64'd1);
        check("rd_m0_rdata", m_rdata[0], data);
        check("rd_s_rready", 64'(s_rready), 64'd1);
        check("rd_m1_quiet_r", 64'(m_bits(1)) | m_rdata[1], 64'd0);
        @(negedge clk);
        s_rvalid = 1'b0; m_rready[0] = 1'b0;
        #1 check("rd_back_idle", 64'(hs_bits()), 64'd0);
    endtask

    // ---------------- randomized traffic engine ----------------
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } txn_t;

    txn_t     tx [2][64];
    int       n_tx [2];
    int       idx [2];
    int       gap [2];
    int       aw_wait [2];
    int       w_wait [2];
    bit [1:0] act, ar_d, aw_d, w_d;
    bit       bus_free, last_g, own;
    int       grant_log [256];
    int       n_grants;

    task automatic run_engine(input bit rnd, input int budget);
        bit                rd_pend, aw_got, w_got, b_pend, was_free, any_done, chk_grant, exp_rd, w;
        logic [ADDR_W-1:0] rd_addr, wr_addr;
        logic [1:0]        req;
        int                r_dly, b_dly, cyc, nown;
        txn_t              t;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; chk_grant = 0; exp_rd = 0;
        rd_addr = '0; wr_addr = '0; r_dly = 0; b_dly = 0; cyc = 0;
        bus_free = 1; last_g = 0; own = 0; n_grants = 0;
        act = '0; ar_d = '0; aw_d = '0; w_d = '0;
        for (int i = 0; i < 2; i++) begin idx[i] = 0; gap[i] = 0; aw_wait[i] = 0; w_wait[i] = 0; end
        while (!(idx[0] == n_tx[0] && idx[1] == n_tx[1]) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && idx[i] < n_tx[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        act[i] = 1; ar_d[i] = 0; aw_d[i] = 0; w_d[i] = 0;
                        aw_wait[i] = rnd ? int'($urandom_range(0, 2)) : 0;
                        w_wait[i]  = rnd ? int'($urandom_range(0, 2)) : 0;
                    end
                end
                t = tx[i][idx[i] < n_tx[i] ? idx[i] : 0];
                m_arvalid[i] = act[i] && !t.wr && !ar_d[i];
                m_awvalid[i] = act[i] && t.wr && !aw_d[i] && aw_wait[i] == 0;
                m_wvalid[i]  = act[i] && t.wr && !w_d[i] && w_wait[i] == 0;
                m_araddr[i] = t.addr; m_awaddr[i] = t.addr; m_wdata[i] = t.data; m_wstrb[i] = t.strb;
                m_rready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_bready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (act[i] && aw_wait[i] > 0) aw_wait[i]--;
                if (act[i] && w_wait[i] > 0) w_wait[i]--;
            end
            s_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_rvalid = rd_pend && r_dly == 0;
            s_rdata  = rd_fn(rd_addr); s_rresp = rresp_fn(rd_addr);
            s_bvalid = b_pend && b_dly == 0;
            s_bresp  = bresp_fn(wr_addr);
            #1;
            was_free = bus_free;
            nown = own ? 0 : 1;
            if (was_free) check("idle_quiet", 64'(hs_bits()), 64'd0);
            else begin
                check("nonowner_quiet", 64'(m_bits(nown)), 64'd0);
                check("nonowner_data", m_rdata[nown] | 64'(m_rresp[nown] | m_bresp[nown]), 64'd0);
                if (chk_grant) begin
                    if (exp_rd) check("grant_to_ar", 64'(s_arvalid), 64'd1);
                    else check("grant_to_wr", 64'({s_awvalid, s_wvalid}),
                               64'({m_awvalid[own], m_wvalid[own]}));
                end
            end
            chk_grant = 0;
            t = tx[own][idx[own] < n_tx[own] ? idx[own] : 0];
            if (s_arvalid && s_arready) begin
                check("s_araddr", 64'(s_araddr), 64'(t.addr));
                rd_pend = 1; rd_addr = s_araddr; r_dly = rnd ? int'($urandom_range(0, 2)) : 0;
            end
            if (s_rvalid && s_rready) rd_pend = 0;
            if (s_awvalid && s_awready) begin
                check("s_awaddr", 64'(s_awaddr), 64'(t.addr));
                aw_got = 1; wr_addr = s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                check("s_wdata", s_wdata, t.data);
                check("s_wstrb", 64'(s_wstrb), 64'(t.strb));
                w_got = 1;
            end
            if (s_bvalid && s_bready) begin b_pend = 0; aw_got = 0; w_got = 0; end
            if (aw_got && w_got && !b_pend) begin
                b_pend = 1; b_dly = rnd ? int'($urandom_range(0, 2)) : 0;
            end
            if (rd_pend && r_dly > 0) r_dly--;
            if (b_pend && b_dly > 0) b_dly--;
            any_done = 0;
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    t = tx[i][idx[i]];
                    if (m_arvalid[i] && m_arready[i]) ar_d[i] = 1;
                    if (m_awvalid[i] && m_awready[i]) aw_d[i] = 1;
                    if (m_wvalid[i] && m_wready[i]) w_d[i] = 1;
                    if ((m_rvalid[i] && m_rready[i]) || (m_bvalid[i] && m_bready[i])) begin
                        if (t.wr) check("m_bresp", 64'(m_bresp[i]), 64'(bresp_fn(t.addr)));
                        else begin
                            check("m_rdata", m_rdata[i], rd_fn(t.addr));
                            check("m_rresp", 64'(m_rresp[i]), 64'(rresp_fn(t.addr)));
                        end
                        act[i] = 0; idx[i]++; any_done = 1;
                        gap[i] = rnd ? int'($urandom_range(0, 3)) : 0;
                    end
                end
            end
            if (any_done) bus_free = 1;
            // Bus free this cycle: the rule picks a winner from the requests just presented.
            if (was_free) begin
                req = m_arvalid | m_awvalid | m_wvalid;
                if (req != 2'b00) begin
                    w = (req == 2'b11) ? !last_g : req[1];
                    own = w; last_g = w; bus_free = 0; chk_grant = 1; exp_rd = m_arvalid[w];
                    if (n_grants < 256) grant_log[n_grants] = int'(w);
                    n_grants++;
                end
            end
        end
        check("engine_completed", 64'({idx[0] == n_tx[0], idx[1] == n_tx[1]}), 64'd3);
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Single read on m0.
        read_m0(32'h8000_0000, 64'h1234);

        // Reset asserted in RD_DATA while the slave holds rvalid low.
        @(negedge clk);
        m_arvalid[0] = 1'b1; m_araddr[0] = 32'h8000_0040;
        @(negedge clk);
        s_arready = 1'b1;
        @(negedge clk);
        m_arvalid[0] = 1'b0; s_arready = 1'b0; m_rready[0] = 1'b1;
        #1 check("rstmid_in_rd_data", 64'(s_rready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = 64'h55;
        #1 check("rstmid_quiet", 64'(hs_bits()), 64'd0);
        check("rstmid_rdata", m_rdata[0], 64'd0);
        rst = 1'b0; s_rvalid = 1'b0; m_rready[0] = 1'b0;
        read_m0(32'h8000_0080, 64'hCAFE_F00D_0000_0001);

        // m1 write: W accepted first, AW two cycles later, then one B.
        @(negedge clk);
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1; m_bready[1] = 1'b1;
        m_awaddr[1] = 32'h8000_0100; m_wdata[1] = 64'hDEAD_BEEF; m_wstrb[1] = 8'h0F;
        #1 check("wr_idle_quiet", 64'(hs_bits()), 64'd0);
        @(negedge clk);
        s_wready = 1'b1;
        #1 check("wr_s_valids", 64'({s_awvalid, s_wvalid}), 64'd3);
        check("wr_s_awaddr", 64'(s_awaddr), 64'h8000_0100);
        check("wr_s_wdata", s_wdata, 64'hDEAD_BEEF);
        check("wr_s_wstrb", 64'(s_wstrb), 64'h0F);
        check("wr_m1_readies", 64'({m_awready[1], m_wready[1]}), 64'd1);
        check("wr_m0_quiet", 64'(m_bits(0)), 64'd0);
        @(negedge clk);
        m_wvalid[1] = 1'b0;
        #1 check("wr_w_done_gate", 64'({s_wvalid, m_wready[1], s_awvalid}), 64'd1);
        check("wr_hold_no_bready", 64'(s_bready), 64'd0);
        @(negedge clk);
        #1 check("wr_still_wr", 64'({s_awvalid, s_bready}), 64'd2);
        @(negedge clk);
        s_awready = 1'b1;
        #1 check("wr_m1_awready", 64'(m_awready[1]), 64'd1);
        @(negedge clk);
        m_awvalid[1] = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 32'h5;
        #1 check("wr_m1_bvalid", 64'({m_bvalid[1], s_bready, s_awvalid}), 64'd6);
        check("wr_m1_bresp", 64'(m_bresp[1]), 64'h5);
        @(negedge clk);
        s_bvalid = 1'b0; m_bready[1] = 1'b0;
        #1 check("wr_back_idle", 64'(hs_bits()), 64'd0);

        // m0 write with AW and W in the same cycle: response phase follows immediately.
        @(negedge clk);
        m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1; m_awaddr[0] = 32'h40;
        @(negedge clk);
        s_awready = 1'b1; s_wready = 1'b1;
        #1 check("aww_m0_readies", 64'({m_awready[0], m_wready[0]}), 64'd3);
        @(negedge clk);
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 32'h9;
        #1 check("aww_wr_resp_next", 64'({m_bvalid[0], s_bready}), 64'd3);
        check("aww_m0_bresp", 64'(m_bresp[0]), 64'h9);
        @(negedge clk);
        s_bvalid = 1'b0; m_bready[0] = 1'b0;

        // m1 requests read and write together: read is served first.
        @(negedge clk);
        m_arvalid[1] = 1'b1; m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        m_rready[1] = 1'b1; m_bready[1] = 1'b1; m_araddr[1] = 32'h200; m_awaddr[1] = 32'h300;
        @(negedge clk);
        s_arready = 1'b1;
        #1 check("rw_read_first", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd4);
        @(negedge clk);
        m_arvalid[1] = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'hABCD;
        #1 check("rw_m1_rdata", m_rdata[1], 64'hABCD);
        @(negedge clk);
        s_rvalid = 1'b0;
        #1 check("rw_idle_between", 64'(hs_bits()), 64'd0);
        @(negedge clk);
        s_awready = 1'b1; s_wready = 1'b1;
        #1 check("rw_write_second", 64'({s_awvalid, s_wvalid, s_awaddr == 32'h300}), 64'd7);
        @(negedge clk);
        m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1;
        #1 check("rw_m1_bvalid", 64'(m_bvalid[1]), 64'd1);
        clear_inputs();

        // Continuous contention from the first cycle after reset: strict alternation, m1 first.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_tx[i] = 3;
            for (int k = 0; k < 3; k++)
                tx[i][k] = '{wr: 1'b0, addr: 32'h1000 * (i + 1) + 32'(k * 8), data: '0, strb: '0};
        end
        run_engine(1'b0, 200);
        check("contention_grants", 64'(n_grants), 64'd6);
        for (int k = 0; k < 6; k++) check("contention_order", 64'(grant_log[k]), 64'((k % 2 == 0) ? 1 : 0));

        // Randomized mixed traffic with random readies, delays and AW/W skew.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_tx[i] = 40;
            for (int k = 0; k < 40; k++)
                tx[i][k] = '{wr: 1'($urandom_range(0, 1)), addr: $urandom(),
                             data: {$urandom(), $urandom()}, strb: 8'($urandom())};
        end
        run_engine(1'b1, 6000);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Shares one AXI-lite memory slave between two masters: m0 is the IFU instruction-fetch port and m1 is the LSU data port.
- Sits between the core's fetch/load-store units and the memory/SRAM model.
- Grants whole transactions: one AR+R read, or one AW+W+B write, at a time.
- Uses round-robin arbitration, with m1 winning ties after reset.

Parameters:
- ADDR_W, 32, address width (AR/AW).
- DATA_W, 64, data width (R/W).
- STRB_W, 8, write strobe width (DATA_W/8).
- RESP_W, 32, rresp/bresp width (matches core INST_DATA_BUS).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- m{0,1}_araddr_i  in  ADDR_W  master read address.
- m{0,1}_arvalid_i / m{0,1}_arready_o  in/out  1  master AR handshake.
- m{0,1}_rdata_o  out  DATA_W  read data to master.
- m{0,1}_rresp_o  out  RESP_W  read response to master.
- m{0,1}_rvalid_o / m{0,1}_rready_i  out/in  1  master R handshake.
- m{0,1}_awaddr_i  in  ADDR_W  master write address.
- m{0,1}_awvalid_i / m{0,1}_awready_o  in/out  1  master AW handshake.
- m{0,1}_wdata_i  in  DATA_W  master write data.
- m{0,1}_wstrb_i  in  STRB_W  master write strobes.
- m{0,1}_wvalid_i / m{0,1}_wready_o  in/out  1  master W handshake.
- m{0,1}_bresp_o  out  RESP_W  write response to master.
- m{0,1}_bvalid_o / m{0,1}_bready_i  out/in  1  master B handshake.
- s_araddr_o, s_arvalid_o / s_arready_i  out,out/in  ADDR_W,1/1  slave AR channel.
- s_rdata_i, s_rresp_i  in  DATA_W, RESP_W  slave R payload.
- s_rvalid_i / s_rready_o  in/out  1  slave R handshake.
- s_awaddr_o, s_awvalid_o / s_awready_i  out,out/in  ADDR_W,1/1  slave AW channel.
- s_wdata_o, s_wstrb_o  out  DATA_W, STRB_W  slave W payload.
- s_wvalid_o / s_wready_i  out/in  1  slave W handshake.
- s_bresp_i  in  RESP_W  slave write response.
- s_bvalid_i / s_bready_o  in/out  1  slave B handshake.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP. Registers: owner (1b), last_grant (1b), aw_done, w_done.
- Request definitions:
  - rd_req[i] = m_i_arvalid.
  - wr_req[i] = m_i_awvalid | m_i_wvalid.
  - req[i] = rd_req[i] | wr_req[i].
- Arbitration happens in IDLE only.
  - If both masters request, grant ~last_grant.
  - If only one requests, grant it.
  - Register owner, and set last_grant = owner.
  - Next state is RD_ADDR if the owner has rd_req, else WR. Read beats write when a master asserts both.
  - The slave channel opens the cycle after the grant, so arbitration costs 1 cycle.
- Routing is combinational from the owner only.
  - Slave payload outputs carry the owner's payload.
  - Slave valids/readies are gated by state: s_arvalid only in RD_ADDR; s_rready only in RD_DATA; s_awvalid only in WR & !aw_done; s_wvalid only in WR & !w_done; s_bready only in WR_RESP.
  - Owner-side readies and valids mirror the slave's in the same state. The non-owner sees all readies and valids at 0.
  - Unselected data/resp outputs are 0.
- Read path:
  - RD_ADDR -> RD_DATA on the AR handshake.
  - RD_DATA -> IDLE on the R handshake (s_rvalid & owner rready).
- Write path:
  - In WR, aw_done sets on the AW handshake and w_done sets on the W handshake; they may occur in either order or in the same cycle.
  - WR -> WR_RESP when both are done, counting a handshake in the current cycle.
  - WR_RESP -> IDLE on the B handshake; aw_done and w_done clear at that point.
- Back-to-back: after returning to IDLE, the earliest next grant is the following cycle. Minimum read occupancy is IDLE + RD_ADDR + RD_DATA = 3 cycles.
- Fairness: with both masters continuously requesting, grants alternate strictly.
- Reset values:
  - state = IDLE, owner = 0, last_grant = 0 (so m1 wins the first tie), aw_done = w_done = 0.
  - All valid/ready outputs are 0, and all data/resp outputs are 0.
- Reset asserted mid-transaction: on the next edge the block returns to IDLE and drops all valids/readies. The system-wide reset is trusted to clear the slave too, so no completion of the pending transaction is required.
- A master deasserting its request while ungranted is legal and causes no grant. Once granted, masters hold their valids per AXI rules.
- The block contains no combinational path from any input to an m*_arready/awready/wready in IDLE; these are 0 in IDLE.

Test Plan:
- Single read: m0_arvalid with addr 0x8000_0000; slave arready=1, then rvalid=1, rdata=0x1234 -> s_araddr=0x8000_0000 in RD_ADDR, m0_rdata=0x1234, m0_rvalid=1 in one cycle, back to IDLE; m1 sees no valids.
- Simultaneous first requests: m0 and m1 both arvalid in the first cycle after reset -> m1 granted first, m0 second; both complete with correct rdata routing.
- Continuous contention for 6 transactions -> grant order m1,m0,m1,m0,m1,m0.
- Write with W before AW: m1 write to addr 0x8000_0100, wdata=0xDEAD_BEEF, wstrb=0x0F; slave wready one cycle, awready 2 cycles later, then bvalid -> stays in WR until both done, then a single bvalid/bresp is forwarded to m1.
- Write with AW and W in the same cycle -> WR_RESP next cycle; and read+write requested by one master -> read is served first.
- rst asserted during RD_DATA with slave rvalid low -> next cycle state IDLE, all outputs 0, and a new m0 read then succeeds.
